multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Sequencing controller for the HI/LO resource of the multicycle MIPS datapath.
- Runs iterative signed MULT/DIV and owns the HI and LO registers.
- Arbitrates MFHI/MFLO write-back against an in-flight operation and drives the write-back source select (MemtoReg) and RegWrite for those moves.
- Stalls the main control FSM while a move waits on a busy unit.

Parameters:
ITER, 32, iterations per mult/div (one operand bit per cycle)
SEL_LO, 4'b0100, MemtoReg code selecting LO
SEL_HI, 4'b0101, MemtoReg code selecting HI

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start_mult  input  1  one-cycle request: signed op_a*op_b
start_div  input  1  one-cycle request: signed op_a/op_b
op_a  input  32  multiplicand / dividend
op_b  input  32  multiplier / divisor
mf_req  input  1  one-cycle MFHI/MFLO request
mf_sel  input  1  0=MFLO, 1=MFHI
mf_rd  input  5  destination register of the move
busy  output  1  high in MULT, DIV, FIX states
stall  output  1  combinational; high while a move is pending or requested while busy
done  output  1  registered one-cycle pulse after HI/LO update
div_zero  output  1  sticky; set by DIV with op_b=0, cleared by next start
hi  output  32  HI register
lo  output  32  LO register
mem_to_reg  output  4  SEL_LO/SEL_HI during write-back, else 4'b0000
reg_write  output  1  one-cycle register-file write enable for the move
wb_rd  output  5  register address accompanying reg_write

Behaviour:
- Reset (async, active-high): state IDLE. hi, lo = 0. busy, done, div_zero, reg_write = 0. mem_to_reg = 0. wb_rd = 0. Pending move and counter cleared. Any operation or pending move is aborted, including mid-operation.
- States: IDLE, MULT, DIV, FIX, WB.
- IDLE:
  - start_mult captures |op_a|, |op_b| and result sign, then goes to MULT. Counter = 0. div_zero cleared.
  - start_div with op_b != 0 captures magnitudes and signs, then goes to DIV.
  - start_div with op_b == 0 sets div_zero and pulses done; hi/lo are unchanged and the state stays IDLE.
  - start_mult and start_div together: mult wins.
  - mf_req with no start goes to WB.
- MULT: unsigned shift-add, 64-bit accumulator, one multiplier bit per cycle. After ITER cycles go to FIX.
- DIV: unsigned restoring division, one quotient bit per cycle. After ITER cycles go to FIX.
- FIX (1 cycle):
  - Mult: negate the 64-bit product if signs differ; {hi,lo} = product.
  - Div: lo = quotient, negated if signs differ. hi = remainder, negated if dividend is negative.
  - Results truncate toward zero. INT_MIN/-1 gives lo=0x80000000, hi=0.
  - Pulse done. Next state is WB if a move is pending, else IDLE.
- Latency: start sampled at edge k. Iterations at edges k+1..k+32. hi/lo are written at edge k+33, with done high for the following cycle. busy is high from after edge k through edge k+33.
- Start requests while busy: ignored; the control FSM never issues them.
- Move handling:
  - mf_req while busy latches mf_sel and mf_rd as pending. stall is high from that cycle until WB is entered.
  - mf_req in the same cycle as a start is also latched pending and is serviced after that operation.
  - A second mf_req while one is pending overwrites it.
- WB (1 cycle): reg_write=1, mem_to_reg = mf_sel ? SEL_HI : SEL_LO, wb_rd = mf_rd. The value comes from the post-update hi/lo, then the state returns to IDLE. Outside WB, reg_write=0 and mem_to_reg=0.
- An idle mf_req enters WB at the next edge: reg_write is high for exactly one cycle after the request, and stall stays 0.

Test Plan:
- Reset, then start_mult a=7, b=-3 -> done in the cycle after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high for 33 cycles.
- start_div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi/lo via a mult, then start_div b=0 -> div_zero=1, done one cycle, hi/lo unchanged, busy never high. Next start_mult clears div_zero.
- start_mult 0x10000*0x10000, then mf_req mf_sel=1 mf_rd=9 at cycle 5 -> stall high until FIX. WB cycle has reg_write=1, mem_to_reg=0101, wb_rd=9, hi=1.
- Idle mf_req mf_sel=0 mf_rd=4 -> next cycle reg_write=1, mem_to_reg=0100, wb_rd=4, stall=0 throughout.
- Assert reset at iteration 12 of a mult with a pending move -> all outputs zero immediately, no reg_write and no done afterward.

Source files
------------

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_ctrl
//  Description : HI/LO sequencer for the multicycle MIPS datapath. Runs
//                iterative signed MULT/DIV (one operand bit per cycle), owns
//                HI and LO, and schedules MFHI/MFLO write-back around any
//                in-flight operation, stalling the main FSM while it waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int         ITER   = 32,
    parameter logic [3:0] SEL_LO = 4'b0100,
    parameter logic [3:0] SEL_HI = 4'b0101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mf_req,
    input  logic        mf_sel,
    input  logic [4:0]  mf_rd,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [3:0]  mem_to_reg,
    output logic        reg_write,
    output logic [4:0]  wb_rd
);

    localparam int               CNT_W       = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(ITER - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_MULT = 3'd1;
    localparam logic [2:0] c_DIV  = 3'd2;
    localparam logic [2:0] c_FIX  = 3'd3;
    localparam logic [2:0] c_WB   = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    // Mult: {partial product, remaining multiplier bits}.
    // Div : {partial remainder, dividend bits shifting into quotient}.
    logic [63:0]      r_acc;
    // Multiplicand magnitude for mult, divisor magnitude for div.
    logic [31:0]      r_operand;
    logic             r_isDiv;
    logic             r_negRes;
    logic             r_negRem;
    logic             r_pend;
    logic             r_mvSel;
    logic [4:0]       r_mvRd;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_done;
    logic             r_divZero;

    logic [31:0]      w_absA;
    logic [31:0]      w_absB;
    logic [32:0]      w_mulSum;
    logic [32:0]      w_divShift;
    logic             w_divGe;
    logic [31:0]      w_divDiff;
    logic [63:0]      w_prod;
    logic [31:0]      w_quo;
    logic [31:0]      w_rem;
    logic             w_busy;
    logic             w_wb;

    // Operand magnitudes, one iteration step of each unit, and sign fix-up
    always_comb begin
        w_absA     = op_a[31] ? (32'd0 - op_a) : op_a;
        w_absB     = op_b[31] ? (32'd0 - op_b) : op_b;
        w_mulSum   = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_operand : 32'd0)};
        w_divShift = r_acc[63:31];
        w_divGe    = (w_divShift >= {1'b0, r_operand});
        // When the trial succeeds the true difference is below the divisor,
        // so the low 32 bits hold it exactly.
        w_divDiff  = w_divShift[31:0] - r_operand;
        w_prod     = r_negRes ? (64'd0 - r_acc) : r_acc;
        w_quo      = r_negRes ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        w_rem      = r_negRem ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    end

    // Control FSM, iterative datapath, HI/LO and pending-move bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_operand <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_pend    <= 1'b0;
            r_mvSel   <= 1'b0;
            r_mvRd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start_mult) begin
                        r_operand <= w_absA;
                        r_acc     <= {32'd0, w_absB};
                        r_negRes  <= op_a[31] ^ op_b[31];
                        r_isDiv   <= 1'b0;
                        r_cnt     <= '0;
                        r_divZero <= 1'b0;
                        r_state   <= c_MULT;
                        if (mf_req) begin
                            r_pend  <= 1'b1;
                            r_mvSel <= mf_sel;
                            r_mvRd  <= mf_rd;
                        end
                    end else if (start_div && op_b == 32'd0) begin
                        // Nothing to compute: flag it and leave HI/LO alone.
                        r_divZero <= 1'b1;
                        r_done    <= 1'b1;
                        if (mf_req) begin
                            r_mvSel <= mf_sel;
                            r_mvRd  <= mf_rd;
                            r_pend  <= 1'b0;
                            r_state <= c_WB;
                        end
                    end else if (start_div) begin
                        r_operand <= w_absB;
                        r_acc     <= {32'd0, w_absA};
                        r_negRes  <= op_a[31] ^ op_b[31];
                        r_negRem  <= op_a[31];
                        r_isDiv   <= 1'b1;
                        r_cnt     <= '0;
                        r_divZero <= 1'b0;
                        r_state   <= c_DIV;
                        if (mf_req) begin
                            r_pend  <= 1'b1;
                            r_mvSel <= mf_sel;
                            r_mvRd  <= mf_rd;
                        end
                    end else if (mf_req || r_pend) begin
                        if (mf_req) begin
                            r_mvSel <= mf_sel;
                            r_mvRd  <= mf_rd;
                        end
                        r_pend  <= 1'b0;
                        r_state <= c_WB;
                    end
                end
                c_MULT, c_DIV: begin
                    if (r_state == c_MULT) begin
                        r_acc <= {w_mulSum, r_acc[31:1]};
                    end else if (w_divGe) begin
                        r_acc <= {w_divDiff, r_acc[30:0], 1'b1};
                    end else begin
                        r_acc <= {w_divShift[31:0], r_acc[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= c_FIX;
                    end
                    if (mf_req) begin
                        r_pend  <= 1'b1;
                        r_mvSel <= mf_sel;
                        r_mvRd  <= mf_rd;
                    end
                end
                c_FIX: begin
                    if (r_isDiv) begin
                        r_lo <= w_quo;
                        r_hi <= w_rem;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                    r_done <= 1'b1;
                    if (mf_req) begin
                        r_mvSel <= mf_sel;
                        r_mvRd  <= mf_rd;
                    end
                    if (mf_req || r_pend) begin
                        r_pend  <= 1'b0;
                        r_state <= c_WB;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_WB: begin
                    // A request arriving during write-back is kept for IDLE.
                    if (mf_req) begin
                        r_pend  <= 1'b1;
                        r_mvSel <= mf_sel;
                        r_mvRd  <= mf_rd;
                    end
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign w_busy     = (r_state == c_MULT) || (r_state == c_DIV) || (r_state == c_FIX);
    assign w_wb       = (r_state == c_WB);
    assign busy       = w_busy;
    assign stall      = r_pend || (mf_req && w_busy);
    assign done       = r_done;
    assign div_zero   = r_divZero;
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign reg_write  = w_wb;
    assign mem_to_reg = w_wb ? (r_mvSel ? SEL_HI : SEL_LO) : 4'b0000;
    assign wb_rd      = w_wb ? r_mvRd : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_ctrl
//  Description : Self-checking bench for multdiv_ctrl; signed results are
//                predicted with 64-bit integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        mf_req = 1'b0;
    logic        mf_sel = 1'b0;
    logic [4:0]  mf_rd = '0;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  mem_to_reg;
    logic        reg_write;
    logic [4:0]  wb_rd;

    int nCmp = 0;
    int nBad = 0;

    multdiv_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .mf_req     (mf_req),
        .mf_sel     (mf_sel),
        .mf_rd      (mf_rd),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .wb_rd      (wb_rd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] refProd(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Returns {remainder, quotient}, both truncated toward zero.
    function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 64'(sa / sb);
        r  = 64'(sa % sb);
        return {r[31:0], q[31:0]};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        nCmp++;
        if ({busy, stall, done, div_zero, hi, lo, mem_to_reg, reg_write, wb_rd} !== '0) begin
            nBad++;
            $display("FAIL reset_outputs: got hi=%h lo=%h busy=%b done=%b rw=%b m2r=%h rd=%0d want all zero",
                     hi, lo, busy, done, reg_write, mem_to_reg, wb_rd);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic doMult(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int cyc;
        int busyCyc;
        p = refProd(a, b);
        op_a = a; op_b = b; start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        nCmp++;
        if (div_zero !== 1'b0) begin
            nBad++;
            $display("FAIL mult_clears_divzero: got %b want 0", div_zero);
        end
        cyc = 0; busyCyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy === 1'b1) busyCyc++;
            tick();
            cyc++;
        end
        nCmp++;
        if (cyc != 33) begin
            nBad++;
            $display("FAIL mult_latency %h*%h: got %0d cycles want 33", a, b, cyc);
        end
        nCmp++;
        if (busyCyc != 33) begin
            nBad++;
            $display("FAIL mult_busy_len: got %0d want 33", busyCyc);
        end
        nCmp++;
        if ({hi, lo} !== p) begin
            nBad++;
            $display("FAIL mult_result %h*%h: got %h_%h want %h", a, b, hi, lo, p);
        end
        tick();
        nCmp++;
        if ({done, busy} !== 2'b00) begin
            nBad++;
            $display("FAIL mult_done_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic doDiv(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        logic [31:0] hiPrev;
        logic [31:0] loPrev;
        int cyc;
        e = (b == 32'd0) ? 64'd0 : refDiv(a, b);
        hiPrev = hi; loPrev = lo;
        op_a = a; op_b = b; start_div = 1'b1;
        tick();
        start_div = 1'b0;
        if (b == 32'd0) begin
            nCmp++;
            if ({div_zero, done, busy} !== 3'b110) begin
                nBad++;
                $display("FAIL divzero_flags: got dz=%b done=%b busy=%b want 1 1 0", div_zero, done, busy);
            end
            nCmp++;
            if ({hi, lo} !== {hiPrev, loPrev}) begin
                nBad++;
                $display("FAIL divzero_hilo: got %h_%h want %h_%h", hi, lo, hiPrev, loPrev);
            end
            tick();
            nCmp++;
            if ({div_zero, done, busy} !== 3'b100) begin
                nBad++;
                $display("FAIL divzero_after: got dz=%b done=%b busy=%b want 1 0 0", div_zero, done, busy);
            end
        end else begin
            cyc = 0;
            while (done !== 1'b1 && cyc < 60) begin
                tick();
                cyc++;
            end
            nCmp++;
            if (cyc != 33) begin
                nBad++;
                $display("FAIL div_latency: got %0d cycles want 33", cyc);
            end
            nCmp++;
            if ({hi, lo} !== e) begin
                nBad++;
                $display("FAIL div_result %h/%h: got hi=%h lo=%h want hi=%h lo=%h",
                         a, b, hi, lo, e[63:32], e[31:0]);
            end
            tick();
        end
    endtask

    task automatic test_mult();
        doMult(32'd7, 32'hFFFF_FFFD);
        doMult(32'h8000_0000, 32'h8000_0000);
        doMult(32'd0, 32'h1234_5678);
        for (int i = 0; i < 6; i++) doMult($urandom, $urandom);
    endtask

    task automatic test_div();
        logic [31:0] b;
        doDiv(32'hFFFF_FFF9, 32'd2);
        doDiv(32'h8000_0000, 32'hFFFF_FFFF);
        doDiv(32'd7, 32'hFFFF_FFFD);
        for (int i = 0; i < 6; i++) begin
            b = $urandom;
            if (i == 3) b = b >> 20;
            if (b == 32'd0) b = 32'd1;
            doDiv($urandom, b);
        end
    endtask

    task automatic test_div_zero();
        doMult(32'h0001_2345, 32'hFFFF_0007);
        doDiv($urandom, 32'd0);
        doMult(32'd3, 32'd5);
    endtask

    task automatic test_move_busy();
        int cyc;
        int stallBad;
        op_a = 32'h0001_0000; op_b = 32'h0001_0000; start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        repeat (4) tick();
        mf_req = 1'b1; mf_sel = 1'b1; mf_rd = 5'd9;
        #1;
        nCmp++;
        if (stall !== 1'b1) begin
            nBad++;
            $display("FAIL move_busy_stall_req: got %b want 1", stall);
        end
        tick();
        mf_req = 1'b0;
        cyc = 0; stallBad = 0;
        while (reg_write !== 1'b1 && cyc < 60) begin
            if (stall !== 1'b1) stallBad++;
            tick();
            cyc++;
        end
        nCmp++;
        if (cyc != 28 || stallBad != 0) begin
            nBad++;
            $display("FAIL move_busy_wait: got %0d cycles %0d unstalled want 28 0", cyc, stallBad);
        end
        nCmp++;
        if ({reg_write, mem_to_reg, wb_rd, stall, done} !== {1'b1, 4'b0101, 5'd9, 1'b0, 1'b1}) begin
            nBad++;
            $display("FAIL move_busy_wb: got rw=%b m2r=%b rd=%0d stall=%b done=%b want 1 0101 9 0 1",
                     reg_write, mem_to_reg, wb_rd, stall, done);
        end
        nCmp++;
        if ({hi, lo} !== 64'h0000_0001_0000_0000) begin
            nBad++;
            $display("FAIL move_busy_hilo: got %h_%h want 00000001_00000000", hi, lo);
        end
        tick();
        nCmp++;
        if ({reg_write, mem_to_reg, wb_rd} !== '0) begin
            nBad++;
            $display("FAIL move_busy_after: got rw=%b m2r=%b rd=%0d want 0", reg_write, mem_to_reg, wb_rd);
        end
    endtask

    task automatic test_move_idle();
        logic       sel;
        logic [4:0] rd;
        for (int i = 0; i < 4; i++) begin
            sel = (i == 0) ? 1'b0 : 1'($urandom);
            rd  = (i == 0) ? 5'd4 : 5'($urandom);
            mf_req = 1'b1; mf_sel = sel; mf_rd = rd;
            #1;
            nCmp++;
            if (stall !== 1'b0) begin
                nBad++;
                $display("FAIL move_idle_stall: got %b want 0", stall);
            end
            tick();
            mf_req = 1'b0;
            nCmp++;
            if ({reg_write, mem_to_reg, wb_rd, stall} !== {1'b1, (sel ? 4'b0101 : 4'b0100), rd, 1'b0}) begin
                nBad++;
                $display("FAIL move_idle_wb: got rw=%b m2r=%b rd=%0d stall=%b want 1 %b %0d 0",
                         reg_write, mem_to_reg, wb_rd, stall, (sel ? 4'b0101 : 4'b0100), rd);
            end
            tick();
            nCmp++;
            if ({reg_write, mem_to_reg} !== 5'b0) begin
                nBad++;
                $display("FAIL move_idle_once: got rw=%b m2r=%b want 0", reg_write, mem_to_reg);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e;
        logic [4:0]  rd;
        int cyc;
        a = $urandom; b = $urandom >> 8;
        if (b == 32'd0) b = 32'd3;
        e = refDiv(a, b);
        rd = 5'($urandom);
        op_a = a; op_b = b; start_div = 1'b1;
        mf_req = 1'b1; mf_sel = 1'b0; mf_rd = rd;
        tick();
        start_div = 1'b0; mf_req = 1'b0;
        nCmp++;
        if ({stall, busy} !== 2'b11) begin
            nBad++;
            $display("FAIL b2b_pending: got stall=%b busy=%b want 1 1", stall, busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        nCmp++;
        if ({reg_write, mem_to_reg, wb_rd} !== {1'b1, 4'b0100, rd} || lo !== e[31:0] || hi !== e[63:32]) begin
            nBad++;
            $display("FAIL b2b_wb: got rw=%b m2r=%b rd=%0d lo=%h hi=%h want 1 0100 %0d %h %h",
                     reg_write, mem_to_reg, wb_rd, lo, hi, rd, e[31:0], e[63:32]);
        end
        tick();
        doMult($urandom, $urandom);
    endtask

    task automatic test_reset_mid();
        int noise;
        op_a = $urandom | 32'h1; op_b = 32'h0F0F_0F0F; start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        mf_req = 1'b1; mf_sel = 1'b1; mf_rd = 5'd7;
        tick();
        mf_req = 1'b0;
        repeat (10) tick();
        nCmp++;
        if ({busy, stall} !== 2'b11 || {hi, lo} === 64'd0) begin
            nBad++;
            $display("FAIL reset_mid_pre: got busy=%b stall=%b hilo=%h_%h want 1 1 nonzero", busy, stall, hi, lo);
        end
        #1 reset = 1'b1;
        #1;
        nCmp++;
        if ({busy, stall, done, div_zero, hi, lo, mem_to_reg, reg_write, wb_rd} !== '0) begin
            nBad++;
            $display("FAIL reset_mid_outputs: got hi=%h lo=%h busy=%b stall=%b rw=%b want all zero",
                     hi, lo, busy, stall, reg_write);
        end
        tick();
        reset = 1'b0;
        noise = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (reg_write !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) noise++;
        end
        nCmp++;
        if (noise != 0) begin
            nBad++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", noise);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_move_busy();
        test_move_idle();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
`default_nettype wire
